// File: rtl/store_align_unit.sv
// store_align_unit
//
// Store-path aligner between the execute stage and the data memory/MMIO bus.
// It takes one store request per req_valid/req_ready handshake. It produces a
// registered bus beat that carries the word-aligned address, the byte-lane
// write enables and the lane-shifted write data.
//
// Optional feature macro: STORE_MISALIGN_SPLIT_EN
//   defined   : a store that crosses a bus-word boundary is issued as two
//               consecutive beats (BEAT0 then BEAT1).
//   undefined : no BEAT1 state exists. A boundary-crossing store is treated
//               as a misaligned fault: err pulses and no beat is issued.
//
// Parameters
//   DATA_W      bus data width in bits (32 or 64)
//   ADDR_W      byte-address width
// Ports
//   clk, rst    clock and synchronous active-high reset
//   req_valid   store request valid
//   req_ready   unit can accept a request this cycle
//   req_addr    byte address
//   req_data    right-justified store data
//   req_funct3  size code: SB=000 SH=001 SW=010 SD=011
//   mem_valid   bus beat valid
//   mem_ready   bus accepts the beat
//   mem_addr    word-aligned beat address
//   mem_wdata   lane-aligned write data
//   mem_wea     per-byte write enable
//   err         one-cycle pulse: request rejected, no beat issued
module store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [2:0]          req_funct3,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wea,
    output logic                err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

`ifdef STORE_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1} state_t;
`endif

    // Byte-lane mask over a double-wide window: size_bytes ones starting at ofs.
    function automatic logic [2*NB-1:0] lane_mask(input logic [OFS_W-1:0] ofs,
                                                  input logic [3:0] size);
        logic [2*NB-1:0] m;
        m = {(2*NB){1'b0}};
        for (int i = 0; i < 2*NB; i++) begin
            m[i] = (i >= int'(ofs)) && (i < int'(ofs) + int'(size));
        end
        return m;
    endfunction

    // One half of the double-wide shifted data. Bytes beyond size are zeroed first.
    function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] data,
                                                    input logic [OFS_W-1:0]  ofs,
                                                    input logic [3:0]        size,
                                                    input logic              upper);
        logic [2*DATA_W-1:0] d;
        d = {(2*DATA_W){1'b0}};
        for (int i = 0; i < NB; i++) begin
            if (i < int'(size)) begin
                d[8*i +: 8] = data[8*i +: 8];
            end else begin
                d[8*i +: 8] = 8'h00;
            end
        end
        d = d << {ofs, 3'b000};
        return upper ? d[2*DATA_W-1:DATA_W] : d[DATA_W-1:0];
    endfunction

    // Reserved size codes, and doubleword stores on a 32-bit bus, are rejected.
    function automatic logic is_illegal(input logic [2:0] f3);
        return f3[2] || ((f3[1:0] == 2'b11) && (NB < 8));
    endfunction

    state_t              state_r, state_s;
    logic                mem_valid_r, mem_valid_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [NB-1:0]       mem_wea_r, mem_wea_s;
    logic                err_r, err_s;
`ifdef STORE_MISALIGN_SPLIT_EN
    logic                has_b1_r, has_b1_s;
    logic [ADDR_W-1:0]   hi_addr_r, hi_addr_s;
    logic [DATA_W-1:0]   hi_wdata_r, hi_wdata_s;
    logic [NB-1:0]       hi_wea_r, hi_wea_s;
`endif

    logic [3:0]          size_s;
    logic [OFS_W-1:0]    ofs_s;
    logic [2*NB-1:0]     m2_s;
    logic [ADDR_W-1:0]   base_s;
    logic                cross_s, fault_s, last_s, done_s, ready_s, accept_s;

    // Request decode plus handshake terms shared by next-state logic and req_ready.
    always_comb begin
        size_s  = 4'd1 << req_funct3[1:0];
        ofs_s   = req_addr[OFS_W-1:0];
        m2_s    = lane_mask(ofs_s, size_s);
        base_s  = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        cross_s = |m2_s[2*NB-1:NB];
`ifdef STORE_MISALIGN_SPLIT_EN
        fault_s = is_illegal(req_funct3);
        last_s  = ((state_r == BEAT0) && !has_b1_r) || (state_r == BEAT1);
`else
        fault_s = is_illegal(req_funct3) || cross_s;
        last_s  = (state_r == BEAT0);
`endif
        // Retiring the last beat frees the unit in the same cycle (no bubble).
        done_s   = mem_valid_r && mem_ready && last_s;
        ready_s  = !rst && ((state_r == IDLE) || done_s);
        accept_s = req_valid && ready_s;
    end

    assign req_ready = ready_s;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wea   = mem_wea_r;
    assign err       = err_r;

    // Next state and next registered outputs. A same-cycle accept overrides retirement.
    always_comb begin
        state_s     = state_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wea_s   = mem_wea_r;
        err_s       = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        has_b1_s    = has_b1_r;
        hi_addr_s   = hi_addr_r;
        hi_wdata_s  = hi_wdata_r;
        hi_wea_s    = hi_wea_r;
`endif
        case (state_r)
            IDLE: begin
                mem_valid_s = 1'b0;
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (has_b1_r) begin
                        state_s     = BEAT1;
                        mem_addr_s  = hi_addr_r;
                        mem_wdata_s = hi_wdata_r;
                        mem_wea_s   = hi_wea_r;
                    end else begin
                        state_s     = IDLE;
                        mem_valid_s = 1'b0;
                        mem_addr_s  = {ADDR_W{1'b0}};
                        mem_wdata_s = {DATA_W{1'b0}};
                        mem_wea_s   = {NB{1'b0}};
                    end
`else
                    state_s     = IDLE;
                    mem_valid_s = 1'b0;
                    mem_addr_s  = {ADDR_W{1'b0}};
                    mem_wdata_s = {DATA_W{1'b0}};
                    mem_wea_s   = {NB{1'b0}};
`endif
                end else begin
                    state_s = state_r;
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_ready) begin
                    state_s     = IDLE;
                    mem_valid_s = 1'b0;
                    mem_addr_s  = {ADDR_W{1'b0}};
                    mem_wdata_s = {DATA_W{1'b0}};
                    mem_wea_s   = {NB{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
`endif
            default: begin
                state_s     = IDLE;
                mem_valid_s = 1'b0;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
                mem_wea_s   = {NB{1'b0}};
            end
        endcase

        if (accept_s) begin
            if (fault_s) begin
                // Rejected request: pulse err, present no beat.
                state_s     = IDLE;
                err_s       = 1'b1;
                mem_valid_s = 1'b0;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
                mem_wea_s   = {NB{1'b0}};
            end else begin
                state_s     = BEAT0;
                mem_valid_s = 1'b1;
                mem_addr_s  = base_s;
                mem_wdata_s = lane_data(req_data, ofs_s, size_s, 1'b0);
                mem_wea_s   = m2_s[NB-1:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                // The second beat is captured now so the request inputs can move on.
                has_b1_s    = cross_s;
                hi_addr_s   = base_s + ADDR_W'(NB);
                hi_wdata_s  = lane_data(req_data, ofs_s, size_s, 1'b1);
                hi_wea_s    = m2_s[2*NB-1:NB];
`endif
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // State and output registers. Reset drops any pending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wea_r   <= {NB{1'b0}};
            err_r       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            has_b1_r    <= 1'b0;
            hi_addr_r   <= {ADDR_W{1'b0}};
            hi_wdata_r  <= {DATA_W{1'b0}};
            hi_wea_r    <= {NB{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wea_r   <= mem_wea_s;
            err_r       <= err_s;
`ifdef STORE_MISALIGN_SPLIT_EN
            has_b1_r    <= has_b1_s;
            hi_addr_r   <= hi_addr_s;
            hi_wdata_r  <= hi_wdata_s;
            hi_wea_r    <= hi_wea_s;
`endif
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Testbench for store_align_unit. It drives a 32-bit instance from a vector
// table plus hand-written stall and reset sequences, and drives a 64-bit
// instance for the doubleword case. Expectations for boundary-crossing stores
// follow STORE_MISALIGN_SPLIT_EN: two beats when it is defined, an err pulse
// when it is not.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wea;
    logic        err;

    logic        req_valid64 = 1'b0;
    logic        req_ready64;
    logic [31:0] req_addr64 = 32'h0;
    logic [63:0] req_data64 = 64'h0;
    logic [2:0]  req_funct3_64 = 3'b000;
    logic        mem_valid64;
    logic [31:0] mem_addr64;
    logic [63:0] mem_wdata64;
    logic [7:0]  mem_wea64;
    logic        err64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_funct3(req_funct3),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wea(mem_wea), .err(err)
    );

    store_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64),
        .req_data(req_data64), .req_funct3(req_funct3_64),
        .mem_valid(mem_valid64), .mem_ready(1'b1), .mem_addr(mem_addr64),
        .mem_wdata(mem_wdata64), .mem_wea(mem_wea64), .err(err64)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        e_err;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  w0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  w1;
        logic [31:0] d1;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request with mem_ready=1 and check the resulting beats or err pulse.
    task automatic run_vec(input vec_t v, input int idx);
        req_addr   = v.addr;
        req_data   = v.data;
        req_funct3 = v.f3;
        req_valid  = 1'b1;
        mem_ready  = 1'b1;
        #1;
        chk($sformatf("v%0d_ready", idx), {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.e_err) begin
            chk($sformatf("v%0d_err", idx), {63'd0, err}, 64'd1);
            chk($sformatf("v%0d_noval", idx), {63'd0, mem_valid}, 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_err_once", idx), {63'd0, err}, 64'd0);
            chk($sformatf("v%0d_noval2", idx), {63'd0, mem_valid}, 64'd0);
        end else begin
            chk($sformatf("v%0d_err0", idx), {63'd0, err}, 64'd0);
            chk($sformatf("v%0d_val0", idx), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("v%0d_addr0", idx), {32'd0, mem_addr}, {32'd0, v.a0});
            chk($sformatf("v%0d_wea0", idx), {60'd0, mem_wea}, {60'd0, v.w0});
            chk($sformatf("v%0d_wdata0", idx), {32'd0, mem_wdata}, {32'd0, v.d0});
            if (v.nb == 2) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d_val1", idx), {63'd0, mem_valid}, 64'd1);
                chk($sformatf("v%0d_addr1", idx), {32'd0, mem_addr}, {32'd0, v.a1});
                chk($sformatf("v%0d_wea1", idx), {60'd0, mem_wea}, {60'd0, v.w1});
                chk($sformatf("v%0d_wdata1", idx), {32'd0, mem_wdata}, {32'd0, v.d1});
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", idx), {63'd0, mem_valid}, 64'd0);
        end
    endtask

    initial begin
        //            addr          data          f3    err  nb  a0            w0     d0            a1            w1     d1
        vt[0] = '{32'h00000100, 32'hDEADBEEF, 3'b010, 1'b0, 1, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'h0,        4'h0, 32'h0};
        vt[1] = '{32'h00000103, 32'hFFFFFFAB, 3'b000, 1'b0, 1, 32'h00000100, 4'h8, 32'hAB000000, 32'h0,        4'h0, 32'h0};
        vt[2] = '{32'h00000102, 32'hABCD1234, 3'b001, 1'b0, 1, 32'h00000100, 4'hC, 32'h12340000, 32'h0,        4'h0, 32'h0};
        vt[3] = '{32'h00000103, 32'h00001234, 3'b001, 1'b0, 2, 32'h00000100, 4'h8, 32'h34000000, 32'h00000104, 4'h1, 32'h00000012};
        vt[4] = '{32'h00000100, 32'h11111111, 3'b011, 1'b1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
        vt[5] = '{32'h00000100, 32'h22222222, 3'b100, 1'b1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
        vt[6] = '{32'h00000101, 32'h11223344, 3'b010, 1'b0, 2, 32'h00000100, 4'hE, 32'h22334400, 32'h00000104, 4'h1, 32'h00000011};
        vt[7] = '{32'hFFFFFFFE, 32'hAABBCCDD, 3'b010, 1'b0, 2, 32'hFFFFFFFC, 4'hC, 32'hCCDD0000, 32'h00000000, 4'h3, 32'h0000AABB};
        vt[8] = '{32'h00000101, 32'h0000005A, 3'b000, 1'b0, 1, 32'h00000100, 4'h2, 32'h00005A00, 32'h0,        4'h0, 32'h0};
`ifndef STORE_MISALIGN_SPLIT_EN
        vt[3].e_err = 1'b1; vt[3].nb = 0;
        vt[6].e_err = 1'b1; vt[6].nb = 0;
        vt[7].e_err = 1'b1; vt[7].nb = 0;
`endif

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_wea", {60'd0, mem_wea}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vt[i], i);
        end

        // Stall: SW held for 3 cycles, then a queued SB is accepted on the retire cycle
        req_addr = 32'h200; req_data = 32'hCAFEF00D; req_funct3 = 3'b010;
        req_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h205; req_data = 32'h00000077; req_funct3 = 3'b000;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_valid", k), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("stall%0d_addr", k), {32'd0, mem_addr}, 64'h200);
            chk($sformatf("stall%0d_wea", k), {60'd0, mem_wea}, 64'hF);
            chk($sformatf("stall%0d_wdata", k), {32'd0, mem_wdata}, 64'hCAFEF00D);
            chk($sformatf("stall%0d_ready", k), {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        #1;
        chk("retire_ready", {63'd0, req_ready}, 64'd1);
        chk("retire_addr", {32'd0, mem_addr}, 64'h200);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("queued_valid", {63'd0, mem_valid}, 64'd1);
        chk("queued_addr", {32'd0, mem_addr}, 64'h204);
        chk("queued_wea", {60'd0, mem_wea}, 64'h2);
        chk("queued_wdata", {32'd0, mem_wdata}, 64'h00007700);
        @(posedge clk); #1;
        chk("queued_idle", {63'd0, mem_valid}, 64'd0);

        // Reset while a beat is pending (BEAT1 of a split SH, or a stalled BEAT0)
`ifdef STORE_MISALIGN_SPLIT_EN
        req_addr = 32'h103; req_data = 32'h00001234; req_funct3 = 3'b001;
        req_valid = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_beat1_wea", {60'd0, mem_wea}, 64'h1);
`else
        req_addr = 32'h300; req_data = 32'h55667788; req_funct3 = 3'b010;
        req_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_beat0_wea", {60'd0, mem_wea}, 64'hF);
`endif
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {63'd0, mem_valid}, 64'd0);
        chk("midrst_wea", {60'd0, mem_wea}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        chk("midrst_idle", {63'd0, mem_valid}, 64'd0);
        chk("midrst_err", {63'd0, err}, 64'd0);

        // 64-bit bus: SD at 0x108 is a single full-width beat
        req_addr64 = 32'h108; req_data64 = 64'h0123456789ABCDEF; req_funct3_64 = 3'b011;
        req_valid64 = 1'b1;
        #1;
        chk("sd64_ready", {63'd0, req_ready64}, 64'd1);
        @(posedge clk); #1;
        req_valid64 = 1'b0;
        chk("sd64_err", {63'd0, err64}, 64'd0);
        chk("sd64_valid", {63'd0, mem_valid64}, 64'd1);
        chk("sd64_addr", {32'd0, mem_addr64}, 64'h108);
        chk("sd64_wea", {56'd0, mem_wea64}, 64'hFF);
        chk("sd64_wdata", mem_wdata64, 64'h0123456789ABCDEF);
        @(posedge clk); #1;
        chk("sd64_idle", {63'd0, mem_valid64}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
